// File: rtl/dfe_axil_reg_slave.sv
// AXI4-Lite register slave for the DataFreqExt core: four 32-bit control registers
// with byte-strobed writes, OKAY-only responses and per-register write pulses.
module dfe_axil_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] REG_OUT,
  output logic [3:0]                      REG_WR_PULSE
);

  localparam int NumBytes = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic {WIdle, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RAddr, RData} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [3:0][C_S_AXI_DATA_WIDTH-1:0] regs_q, regs_d;

  logic                          aw_lat_q, aw_lat_d;
  logic                          w_lat_q, w_lat_d;
  logic [1:0]                    waddr_q, waddr_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NumBytes-1:0]           wstrb_q, wstrb_d;
  logic                          awready_q, awready_d;
  logic                          wready_q, wready_d;
  logic                          bvalid_q, bvalid_d;
  logic [3:0]                    wr_pulse_q, wr_pulse_d;

  logic [1:0]                    raddr_q, raddr_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                          rvalid_q, rvalid_d;
  logic                          arready_q, arready_d;

  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = S_AXI_AWVALID & awready_q;
  assign w_hs  = S_AXI_WVALID & wready_q;
  assign ar_hs = S_AXI_ARVALID & arready_q;

  // Write channel: AW and W latch independently, commit once both are held.
  always_comb begin
    w_state_d  = w_state_q;
    regs_d     = regs_q;
    aw_lat_d   = aw_lat_q;
    w_lat_d    = w_lat_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    wr_pulse_d = '0;
    case (w_state_q)
      WIdle: begin
        if (aw_hs) begin
          aw_lat_d = 1'b1;
          waddr_d  = S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
          w_lat_d = 1'b1;
          wdata_d = S_AXI_WDATA;
          wstrb_d = S_AXI_WSTRB;
        end
        if (aw_lat_q && w_lat_q) begin
          for (int i = 0; i < NumBytes; i++) begin
            if (wstrb_q[i]) regs_d[waddr_q][8*i +: 8] = wdata_q[8*i +: 8];
          end
          aw_lat_d            = 1'b0;
          w_lat_d             = 1'b0;
          bvalid_d            = 1'b1;
          wr_pulse_d[waddr_q] = 1'b1;
          w_state_d           = WResp;
        end
      end
      WResp: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
    // Looking at bvalid_q too keeps READY low for one extra cycle after the B handshake.
    awready_d = ~aw_lat_d & ~bvalid_d & ~bvalid_q;
    wready_d  = ~w_lat_d & ~bvalid_d & ~bvalid_q;
  end

  // Read channel: address latched on AR, data sampled from the registers one edge later.
  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    rvalid_d  = rvalid_q;
    case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          raddr_d   = S_AXI_ARADDR[3:2];
          r_state_d = RAddr;
        end
      end
      RAddr: begin
        rdata_d   = regs_q[raddr_q];
        rvalid_d  = 1'b1;
        r_state_d = RData;
      end
      RData: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
    arready_d = (r_state_d == RIdle) && (r_state_q == RIdle);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q  <= WIdle;
      r_state_q  <= RIdle;
      regs_q     <= '0;
      aw_lat_q   <= 1'b0;
      w_lat_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      wr_pulse_q <= '0;
      raddr_q    <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      regs_q     <= regs_d;
      aw_lat_q   <= aw_lat_d;
      w_lat_q    <= w_lat_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      wr_pulse_q <= wr_pulse_d;
      raddr_q    <= raddr_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      arready_q  <= arready_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign REG_OUT       = regs_q;
  assign REG_WR_PULSE  = wr_pulse_q;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:4], S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_dfe_axil_reg_slave.sv
// Bench for dfe_axil_reg_slave: directed vector table, hand-built corner sequences and
// random traffic checked against an array-based register model.
module tb_dfe_axil_reg_slave;

  logic         tb_ACLK = 1'b0;
  logic         tb_ARESET;
  logic [31:0]  S_AXI_AWADDR;
  logic [2:0]   S_AXI_AWPROT;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [31:0]  S_AXI_ARADDR;
  logic [2:0]   S_AXI_ARPROT;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [127:0] REG_OUT;
  logic [3:0]   REG_WR_PULSE;

  always #5 tb_ACLK = ~tb_ACLK;

  dfe_axil_reg_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(32)
  ) dut (
    .ACLK         (tb_ACLK),
    .ARESET       (tb_ARESET),
    .S_AXI_AWADDR (S_AXI_AWADDR),
    .S_AXI_AWPROT (S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA  (S_AXI_WDATA),
    .S_AXI_WSTRB  (S_AXI_WSTRB),
    .S_AXI_WVALID (S_AXI_WVALID),
    .S_AXI_WREADY (S_AXI_WREADY),
    .S_AXI_BRESP  (S_AXI_BRESP),
    .S_AXI_BVALID (S_AXI_BVALID),
    .S_AXI_BREADY (S_AXI_BREADY),
    .S_AXI_ARADDR (S_AXI_ARADDR),
    .S_AXI_ARPROT (S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA  (S_AXI_RDATA),
    .S_AXI_RRESP  (S_AXI_RRESP),
    .S_AXI_RVALID (S_AXI_RVALID),
    .S_AXI_RREADY (S_AXI_RREADY),
    .REG_OUT      (REG_OUT),
    .REG_WR_PULSE (REG_WR_PULSE)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model [4];

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lead;   // >0: W leads AW by this many cycles, <0: AW leads W
    logic [31:0] raddr;
    logic [31:0] rexp;
    logic [3:0]  pulse;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] res = old;
    for (int b = 0; b < 4; b++) if (strb[b]) res[8*b +: 8] = nw[8*b +: 8];
    return res;
  endfunction

  function automatic logic [127:0] model_flat();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  task automatic tick();
    @(posedge tb_ACLK);
    #1;
  endtask

  // Drive AW and W (skewed by lead), wait for BVALID, check response and register effect.
  task automatic write_req(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int lead);
    int  cyc = 0;
    int  lat = 0;
    int  aw_start = (lead > 0) ? lead : 0;
    int  w_start  = (lead < 0) ? -lead : 0;
    bit  aw_done = 0, w_done = 0, aw_fire, w_fire;
    S_AXI_AWADDR = addr;
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = strb;
    while (!(aw_done && w_done) && cyc < 30) begin
      if (!aw_done && cyc >= aw_start) S_AXI_AWVALID = 1'b1;
      if (!w_done && cyc >= w_start) S_AXI_WVALID = 1'b1;
      aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
      w_fire  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      cyc++;
      if (aw_fire) begin
        aw_done = 1;
        S_AXI_AWVALID = 1'b0;
        check("awready_drop", S_AXI_AWREADY, 0);
      end
      if (w_fire) begin
        w_done = 1;
        S_AXI_WVALID = 1'b0;
        check("wready_drop", S_AXI_WREADY, 0);
      end
    end
    if (!(aw_done && w_done)) begin
      timeout("write_handshake");
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      return;
    end
    while (!S_AXI_BVALID && lat < 20) begin
      tick();
      lat++;
    end
    check("bvalid_latency", lat, 1);
    model[addr[3:2]] = merge(model[addr[3:2]], data, strb);
    check("bresp", S_AXI_BRESP, 2'b00);
    check("wr_pulse", REG_WR_PULSE, 4'b0001 << addr[3:2]);
    check("reg_out", REG_OUT, model_flat());
  endtask

  // Hold BREADY low for delay cycles, then accept B and confirm READY recovery.
  task automatic write_resp(input int delay);
    for (int i = 0; i < delay; i++) begin
      tick();
      check("bvalid_hold", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 3'b100);
      if (i == 0) check("wr_pulse_one_cycle", REG_WR_PULSE, 0);
    end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check("bvalid_clear", S_AXI_BVALID, 0);
    check("ready_late", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
    check("wr_pulse_clear", REG_WR_PULSE, 0);
    tick();
    check("ready_back", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 3'b011);
  endtask

  task automatic read_req(input logic [31:0] addr, output logic [31:0] data);
    int          c = 0;
    int          lat = 0;
    bit          fired = 0, fire;
    logic [31:0] exp = '0;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    while (!fired && c < 20) begin
      fire = S_AXI_ARREADY;
      exp  = model[addr[3:2]];
      tick();
      c++;
      if (fire) begin
        fired = 1;
        S_AXI_ARVALID = 1'b0;
        check("arready_drop", S_AXI_ARREADY, 0);
      end
    end
    data = '0;
    if (!fired) begin
      timeout("read_handshake");
      S_AXI_ARVALID = 1'b0;
      return;
    end
    while (!S_AXI_RVALID && lat < 20) begin
      tick();
      lat++;
    end
    check("rvalid_latency", lat, 1);
    check("rresp", S_AXI_RRESP, 2'b00);
    check("rdata_model", S_AXI_RDATA, exp);
    data = S_AXI_RDATA;
  endtask

  task automatic read_resp(input int delay, input logic [31:0] exp);
    for (int i = 0; i < delay; i++) begin
      tick();
      check("rvalid_hold", {S_AXI_RVALID, S_AXI_ARREADY}, 2'b10);
      check("rdata_stable", S_AXI_RDATA, exp);
    end
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    check("rvalid_clear", {S_AXI_RVALID, S_AXI_ARREADY}, 2'b00);
    tick();
    check("arready_back", S_AXI_ARREADY, 1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] old;
    logic [31:0] a, d;
    logic [3:0]  s;
    int          lead;

    vecs[0] = '{32'h0,        32'h0101FFFF, 4'hF,  0, 32'h0,        32'h0101FFFF, 4'b0001};
    vecs[1] = '{32'h4,        32'hABCD0001, 4'hF,  0, 32'h4,        32'hABCD0001, 4'b0010};
    vecs[2] = '{32'h8,        32'hDEAD0011, 4'hF,  0, 32'h8,        32'hDEAD0011, 4'b0100};
    vecs[3] = '{32'hC,        32'hBEEF0011, 4'hF,  0, 32'hC,        32'hBEEF0011, 4'b1000};
    vecs[4] = '{32'h4,        32'h12345678, 4'hF,  3, 32'h4,        32'h12345678, 4'b0010};
    vecs[5] = '{32'h8,        32'hFFFFFFFF, 4'h5,  0, 32'h8,        32'hDEFF00FF, 4'b0100};
    vecs[6] = '{32'h13,       32'hCAFEF00D, 4'hF, -2, 32'hFFFFFFF0, 32'hCAFEF00D, 4'b0001};
    vecs[7] = '{32'h1E,       32'h00FF0000, 4'hC,  1, 32'h2C,       32'h00FF0011, 4'b1000};

    for (int i = 0; i < 4; i++) model[i] = '0;
    tb_ARESET     = 1'b1;
    S_AXI_AWADDR  = '0;
    S_AXI_AWPROT  = 3'b010;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = '0;
    S_AXI_WSTRB   = '0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    S_AXI_ARADDR  = '0;
    S_AXI_ARPROT  = 3'b001;
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b0;
    repeat (3) tick();
    tb_ARESET = 1'b0;

    // First cycle after reset release: READYs still low.
    check("reset_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    check("reset_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    check("reset_regs", REG_OUT, 0);
    check("reset_rdata", S_AXI_RDATA, 0);
    check("reset_pulse", REG_WR_PULSE, 0);
    tick();
    check("idle_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    for (int i = 0; i < 4; i++) begin
      read_req(32'(i * 4), rd);
      check("reset_readback", rd, 0);
      read_resp(0, 32'h0);
    end

    // Directed vector table.
    foreach (vecs[i]) begin
      write_req(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, vecs[i].lead);
      check("vec_pulse", REG_WR_PULSE, vecs[i].pulse);
      write_resp(0);
      read_req(vecs[i].raddr, rd);
      check("vec_readback", rd, vecs[i].rexp);
      read_resp(0, vecs[i].rexp);
    end

    // BREADY stall: a read completes while B is held.
    write_req(32'h4, 32'h0BADBEEF, 4'hF, 0);
    read_req(32'h0, rd);
    read_resp(0, model[0]);
    check("b_stall_during_read", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 3'b100);
    write_resp(5);

    // RREADY stall: a write completes while R is held.
    old = model[2];
    read_req(32'h8, rd);
    write_req(32'h8, 32'h11223344, 4'hF, 0);
    write_resp(0);
    check("r_stall_rvalid", {S_AXI_RVALID, S_AXI_RDATA}, {1'b1, old});
    read_resp(5, old);

    // Read sampling the register on the edge a write commits sees the old value.
    old = model[3];
    S_AXI_AWADDR = 32'hC; S_AXI_WDATA = 32'h5A5A5A5A; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 32'hC;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    tick();
    model[3] = 32'h5A5A5A5A;
    check("collide_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
    check("collide_rdata_old", S_AXI_RDATA, old);
    check("collide_reg_new", REG_OUT, model_flat());
    write_resp(0);
    read_resp(0, old);

    // Reset while BVALID is up and a read is latched but not yet answered.
    write_req(32'h0, 32'h55AA55AA, 4'hF, 0);
    S_AXI_ARADDR = 32'h0; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    tb_ARESET = 1'b1;
    tick();
    tb_ARESET = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    check("midrst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    check("midrst_regs", REG_OUT, 0);
    check("midrst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    check("midrst_rdata", S_AXI_RDATA, 0);
    tick();
    check("midrst_recover", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                             S_AXI_RVALID}, 5'b11100);
    write_req(32'h8, 32'h0F0F0F0F, 4'hF, 0);
    write_resp(0);
    read_req(32'h8, rd);
    check("midrst_readback", rd, 32'h0F0F0F0F);
    read_resp(0, 32'h0F0F0F0F);

    // Random traffic against the register model.
    for (int it = 0; it < 60; it++) begin
      a = $urandom;
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      lead = int'($urandom_range(0, 4)) - 2;
      if ($urandom_range(0, 1) == 1) begin
        write_req(a, d, s, lead);
        write_resp(int'($urandom_range(0, 2)));
      end else begin
        old = model[a[3:2]];
        read_req(a, rd);
        read_resp(int'($urandom_range(0, 2)), old);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
